// File: rtl/register_file_mp_pkg.sv
// Shared types and helpers for the multi-read-port register file.
// Holds the FSM state encoding and the address-width helper.
package rf_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

    // Address width for a given depth; a depth of 2 still needs one address bit.
    function automatic int rf_aw(int depth);
        int aw;
        aw = 1;
        while ((1 << aw) < depth) begin
            aw++;
        end
        return aw;
    endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Write/read bus of the multi-read-port register file.
// AW must equal rf_aw(DEPTH) of the attached register file.
interface register_file_mp_if #(
    parameter int WIDTH  = 32,
    parameter int AW     = 5,
    parameter int NUM_RD = 2
);
    logic                      rf_en;
    logic [AW-1:0]             write_addr;
    logic [WIDTH-1:0]          write_data;
    logic [NUM_RD*AW-1:0]      read_addr;
    logic [NUM_RD*WIDTH-1:0]   read_data;
    logic                      ready;

    modport master (
        output rf_en, write_addr, write_data, read_addr,
        input  read_data, ready
    );

    modport slave (
        input  rf_en, write_addr, write_data, read_addr,
        output read_data, ready
    );
endinterface

// File: rtl/register_file_mp_read_port.sv
// One combinational read port: forces zero while clearing or on the hardwired
// zero entry, otherwise forwards same-cycle write data or returns the array word.
module rf_read_port #(
    parameter int WIDTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic             running,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] data
);
    logic is_zero_entry;
    logic bypass_hit;

    assign is_zero_entry = (ZERO_REG != 0) && (addr == '0);
    assign bypass_hit    = (BYPASS != 0) && wr_en && (addr == wr_addr);

    always_comb begin
        data = mem_data;
        if (!running || is_zero_entry) begin
            data = '0;
        end else if (bypass_hit) begin
            data = wr_data;
        end
    end
endmodule

// File: rtl/register_file_mp.sv
// Parametrised single-write, multi-read register file with a post-reset clear
// sweep that zeroes the array one entry per cycle before accepting writes.
module register_file_mp
    import rf_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic               clk,
    input  logic               rst,
    register_file_mp_if.slave  bus
);
    localparam int AW = rf_aw(DEPTH);
    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

    rf_state_t        state_reg, state_next;
    logic [AW:0]      sweep_idx_reg, sweep_idx_next;
    logic             ready_reg, ready_next;

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RF_CLEAR;
            sweep_idx_reg <= '0;
            ready_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sweep_idx_reg <= sweep_idx_next;
            ready_reg     <= ready_next;
        end
    end

    // The sweep counter only advances in CLEAR, so it parks at DEPTH once running.
    always_comb begin
        state_next     = state_reg;
        sweep_idx_next = sweep_idx_reg;
        ready_next     = ready_reg;
        mem_we         = 1'b0;
        mem_waddr      = bus.write_addr;
        mem_wdata      = bus.write_data;
        unique case (state_reg)
            RF_CLEAR: begin
                mem_we         = 1'b1;
                mem_waddr      = sweep_idx_reg[AW-1:0];
                mem_wdata      = '0;
                sweep_idx_next = sweep_idx_reg + (AW+1)'(1);
                if (sweep_idx_reg == LAST_IDX) begin
                    state_next = RF_RUN;
                    ready_next = 1'b1;
                end
            end
            RF_RUN: begin
                mem_we = bus.rf_en && !((ZERO_REG != 0) && (bus.write_addr == '0));
            end
        endcase
    end

    // Array has no reset of its own; a held reset must not disturb its contents.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.ready = ready_reg;

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;

        assign addr = bus.read_addr[gi*AW +: AW];

        rf_read_port #(
            .WIDTH    (WIDTH),
            .AW       (AW),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .running  (state_reg == RF_RUN),
            .addr     (addr),
            .mem_data (mem[addr]),
            .wr_en    (bus.rf_en),
            .wr_addr  (bus.write_addr),
            .wr_data  (bus.write_data),
            .data     (data)
        );

        assign bus.read_data[gi*WIDTH +: WIDTH] = data;
    end
endmodule

// File: tb/tb_register_file_mp.sv
// Directed and model-checked stimulus for register_file_mp in three configurations:
// default, ZERO_REG=0 and BYPASS=0, all driven with the same bus traffic.
module tb_register_file_mp;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    logic [31:0] m  [32];
    logic [31:0] mz [32];
    logic        r_en;
    logic [4:0]  r_wa, r_ra0, r_ra1;
    logic [31:0] r_wd;
    logic [31:0] e0, e1;

    register_file_mp_if #(.WIDTH(32), .AW(5), .NUM_RD(2)) bus    ();
    register_file_mp_if #(.WIDTH(32), .AW(5), .NUM_RD(2)) bus_nz ();
    register_file_mp_if #(.WIDTH(32), .AW(5), .NUM_RD(2)) bus_nb ();

    register_file_mp #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u_dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    register_file_mp #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(0), .BYPASS(1)) u_nz (
        .clk (clk), .rst (rst), .bus (bus_nz)
    );
    register_file_mp #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) u_nb (
        .clk (clk), .rst (rst), .bus (bus_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic en, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        bus.rf_en         = en;  bus.write_addr    = wa;  bus.write_data    = wd;
        bus.read_addr     = {ra1, ra0};
        bus_nz.rf_en      = en;  bus_nz.write_addr = wa;  bus_nz.write_data = wd;
        bus_nz.read_addr  = {ra1, ra0};
        bus_nb.rf_en      = en;  bus_nb.write_addr = wa;  bus_nb.write_data = wd;
        bus_nb.read_addr  = {ra1, ra0};
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready",    {31'b0, bus.ready},    32'd0);
        chk("reset_ready_nz", {31'b0, bus_nz.ready}, 32'd0);
        chk("reset_ready_nb", {31'b0, bus_nb.ready}, 32'd0);
        $display("[TB] reset held 3 cycles, ready=%0d", bus.ready);

        // Clear sweep with a write to 5 that must be dropped
        rst = 1'b0;
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd7);
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            if (k == 32) drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
            #1;
            if (k < 32) begin
                chk("sweep_ready_low", {31'b0, bus.ready}, 32'd0);
                chk("sweep_read_p0",   bus.read_data[31:0],  32'd0);
                chk("sweep_read_p1",   bus.read_data[63:32], 32'd0);
            end else begin
                chk("sweep_ready_high",    {31'b0, bus.ready},    32'd1);
                chk("sweep_ready_high_nz", {31'b0, bus_nz.ready}, 32'd1);
                chk("sweep_ready_high_nb", {31'b0, bus_nb.ready}, 32'd1);
                chk("dropped_write_5",     bus.read_data[31:0],   32'd0);
                chk("dropped_write_5_nb",  bus_nb.read_data[31:0], 32'd0);
            end
        end
        $display("[TB] sweep done, read[5]=%h", bus.read_data[31:0]);

        // Basic write then read on both ports
        cycle();
        drive(1'b1, 5'd7, 32'h12345678, 5'd0, 5'd0);
        cycle();
        drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
        #1;
        chk("wr7_p0",    bus.read_data[31:0],    32'h12345678);
        chk("wr7_p1",    bus.read_data[63:32],   32'h12345678);
        chk("wr7_p0_nb", bus_nb.read_data[31:0], 32'h12345678);
        $display("[TB] write 7 -> p0=%h p1=%h", bus.read_data[31:0], bus.read_data[63:32]);

        // Entry 0 hardwired vs ordinary
        cycle();
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        #1;
        chk("zero_same_p0",    bus.read_data[31:0],    32'd0);
        chk("zero_same_p1",    bus.read_data[63:32],   32'd0);
        chk("zero_same_nz_p0", bus_nz.read_data[31:0], 32'hFFFFFFFF);
        cycle();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        #1;
        chk("zero_next_p0",    bus.read_data[31:0],    32'd0);
        chk("zero_next_nz_p0", bus_nz.read_data[31:0], 32'hFFFFFFFF);
        chk("zero_next_nb_p0", bus_nb.read_data[31:0], 32'd0);
        $display("[TB] write 0 -> zreg=%h nz=%h", bus.read_data[31:0], bus_nz.read_data[31:0]);

        // Bypass vs no bypass
        cycle();
        drive(1'b1, 5'd10, 32'h0BADF00D, 5'd0, 5'd0);
        cycle();
        drive(1'b1, 5'd9, 32'h99999999, 5'd0, 5'd0);
        cycle();
        drive(1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd10);
        #1;
        chk("byp_p0",    bus.read_data[31:0],     32'hA5A5A5A5);
        chk("byp_p1",    bus.read_data[63:32],    32'h0BADF00D);
        chk("nobyp_p0",  bus_nb.read_data[31:0],  32'h99999999);
        chk("nobyp_p1",  bus_nb.read_data[63:32], 32'h0BADF00D);
        cycle();
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd10);
        #1;
        chk("nobyp_next_p0", bus_nb.read_data[31:0], 32'hA5A5A5A5);
        chk("byp_next_p0",   bus.read_data[31:0],    32'hA5A5A5A5);
        $display("[TB] bypass: byp=%h nobyp_next=%h", bus.read_data[31:0], bus_nb.read_data[31:0]);

        // Reset during a second sweep restarts it
        cycle();
        drive(1'b1, 5'd3, 32'h00000011, 5'd0, 5'd0);
        cycle();
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        #1;
        chk("wr3_p0", bus.read_data[31:0], 32'h00000011);
        rst = 1'b1;
        cycle();
        chk("rst_run_ready", {31'b0, bus.ready}, 32'd0);
        rst = 1'b0;
        repeat (20) cycle();
        chk("mid_sweep_ready", {31'b0, bus.ready}, 32'd0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            cycle();
            chk("resweep_ready", {31'b0, bus.ready}, (k < 32) ? 32'd0 : 32'd1);
            chk("resweep_p0",    bus.read_data[31:0], 32'd0);
        end
        chk("rd3_after_nz", bus_nz.read_data[31:0], 32'd0);
        chk("rd3_after_nb", bus_nb.read_data[31:0], 32'd0);
        $display("[TB] restarted sweep done, read[3]=%h", bus.read_data[31:0]);

        // Random traffic against reference models
        for (int i = 0; i < 32; i++) begin
            m[i]  = 32'd0;
            mz[i] = 32'd0;
        end
        for (int n = 0; n < 2000; n++) begin
            r_en  = 1'($urandom_range(0, 1));
            r_wa  = 5'($urandom_range(0, 31));
            r_wd  = $urandom;
            r_ra0 = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
            r_ra1 = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
            drive(r_en, r_wa, r_wd, r_ra0, r_ra1);
            #1;
            e0 = (r_ra0 == 5'd0) ? 32'd0 : ((r_en && r_ra0 == r_wa) ? r_wd : m[r_ra0]);
            e1 = (r_ra1 == 5'd0) ? 32'd0 : ((r_en && r_ra1 == r_wa) ? r_wd : m[r_ra1]);
            chk("rand_p0", bus.read_data[31:0],  e0);
            chk("rand_p1", bus.read_data[63:32], e1);
            chk("rand_nb_p0", bus_nb.read_data[31:0],  (r_ra0 == 5'd0) ? 32'd0 : m[r_ra0]);
            chk("rand_nb_p1", bus_nb.read_data[63:32], (r_ra1 == 5'd0) ? 32'd0 : m[r_ra1]);
            chk("rand_nz_p0", bus_nz.read_data[31:0],  (r_en && r_ra0 == r_wa) ? r_wd : mz[r_ra0]);
            chk("rand_nz_p1", bus_nz.read_data[63:32], (r_en && r_ra1 == r_wa) ? r_wd : mz[r_ra1]);
            @(posedge clk);
            #1;
            if (r_en && r_wa != 5'd0) m[r_wa] = r_wd;
            if (r_en) mz[r_wa] = r_wd;
        end
        $display("[TB] random phase: 2000 cycles checked");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
